// File: rtl/tribus_if.sv
// Handshake bundle for the four-requester tri-state bus arbiter.
// Requesters use the master modport and the arbiter uses the slave modport.
interface tribus_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [3:0]       ena;
  logic [1:0]       gnt_id;
  logic             busy;

  modport master (
    output req,
    output din0,
    output din1,
    output din2,
    output din3,
    input  ena,
    input  gnt_id,
    input  busy
  );

  modport slave (
    input  req,
    input  din0,
    input  din1,
    input  din2,
    input  din3,
    output ena,
    output gnt_id,
    output busy
  );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a 4-way tri-state bus with a one-cycle turnaround between owners.
// Define TRIBUS_TIMEOUT_EN to force a turnaround after MAX_HOLD consecutive GRANT cycles.
module tribus_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tribus_if.slave          arb,
  output wire  [WIDTH-1:0] bus
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  if (MAX_HOLD < 1) begin : g_max_hold_check
    $fatal(1, "tribus_arbiter: MAX_HOLD must be at least 1");
  end

  state_e     state_q;
  logic [3:0] ena_q;
  logic [1:0] gnt_id_q;
  logic [1:0] last_id_q;
  logic       busy_q;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;
  logic       hold_done;

`ifdef TRIBUS_TIMEOUT_EN
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  // Counts completed GRANT cycles of the current owner, cleared on every new grant.
  logic [HoldW-1:0] hold_q;

  assign hold_done = (hold_q == HoldW'(MAX_HOLD - 1));
`else
  assign hold_done = 1'b0;
`endif

  // Search starts just after the last owner, so the previous owner is tried last.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_id_q;
    cand      = last_id_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id_q + 2'(k);
      if (!win_found && arb.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ena_q     <= 4'b0000;
      busy_q    <= 1'b0;
      gnt_id_q  <= 2'd0;
      last_id_q <= 2'd3;
`ifdef TRIBUS_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StTurn: begin
          if (win_found) begin
            state_q   <= StGrant;
            ena_q     <= 4'b0001 << win_id;
            busy_q    <= 1'b1;
            gnt_id_q  <= win_id;
            last_id_q <= win_id;
`ifdef TRIBUS_TIMEOUT_EN
            hold_q    <= '0;
`endif
          end else begin
            state_q <= StIdle;
            ena_q   <= 4'b0000;
            busy_q  <= 1'b0;
          end
        end
        StGrant: begin
          if (!arb.req[gnt_id_q] || hold_done) begin
            state_q <= StTurn;
            ena_q   <= 4'b0000;
            busy_q  <= 1'b0;
          end
`ifdef TRIBUS_TIMEOUT_EN
          else begin
            hold_q <= hold_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          ena_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.ena    = ena_q;
  assign arb.gnt_id = gnt_id_q;
  assign arb.busy   = busy_q;

  assign bus = ena_q[0] ? arb.din0 : {WIDTH{1'bz}};
  assign bus = ena_q[1] ? arb.din1 : {WIDTH{1'bz}};
  assign bus = ena_q[2] ? arb.din2 : {WIDTH{1'bz}};
  assign bus = ena_q[3] ? arb.din3 : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: reset, single grant, round-robin rotation, hold/timeout,
// reset during GRANT, turnaround priority and a random-request bus-safety sweep.
module tb_tribus_arbiter;

  logic       clk;
  logic       rst_n;
  wire  [7:0] bus;

  int tests;
  int fails;

  logic [7:0] din_v [4];
  logic [3:0] prev_ena;

  tribus_if #(.WIDTH(8)) arb ();

  tribus_arbiter #(
    .WIDTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb.slave),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign arb.din0 = din_v[0];
  assign arb.din1 = din_v[1];
  assign arb.din2 = din_v[2];
  assign arb.din3 = din_v[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    arb.req = 4'b1111;
    step();
    step();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    din_v[0] = 8'h11;
    din_v[1] = 8'h22;
    din_v[2] = 8'hA5;
    din_v[3] = 8'h44;
    rst_n    = 1'b0;
    arb.req  = 4'b0000;

    // Reset with all requests high: requests are ignored.
    do_reset();
    chk("rst_ena", arb.ena, 4'b0000);
    chk("rst_busy", arb.busy, 1'b0);
    chk("rst_gnt_id", arb.gnt_id, 2'd0);

    // Single request from requester 2.
    rst_n   = 1'b1;
    arb.req = 4'b0100;
    step();
    chk("one_ena", arb.ena, 4'b0100);
    chk("one_gnt_id", arb.gnt_id, 2'd2);
    chk("one_busy", arb.busy, 1'b1);
    chk("one_bus", bus, 8'hA5);
    arb.req = 4'b0000;
    step();
    chk("one_turn_ena", arb.ena, 4'b0000);
    chk("one_turn_busy", arb.busy, 1'b0);
    chk("one_turn_gnt_id", arb.gnt_id, 2'd2);
    step();
    chk("one_idle_ena", arb.ena, 4'b0000);
    chk("one_idle_gnt_id", arb.gnt_id, 2'd2);

    // All requests high, each owner drops for one cycle after 3 GRANT cycles.
    do_reset();
    rst_n   = 1'b1;
    arb.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk("rr_ena", arb.ena, 4'b0001 << (k % 4));
        chk("rr_gnt_id", arb.gnt_id, k % 4);
        chk("rr_bus", bus, din_v[k % 4]);
        if (c < 2) step();
      end
      arb.req[k % 4] = 1'b0;
      step();
      chk("rr_turn_ena", arb.ena, 4'b0000);
      chk("rr_turn_gnt_id", arb.gnt_id, k % 4);
      arb.req = 4'b1111;
      step();
    end

    // Requester 0 alone holds its request.
    do_reset();
    rst_n   = 1'b1;
    arb.req = 4'b0001;
    step();
`ifdef TRIBUS_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      chk("to_hold_ena", arb.ena, 4'b0001);
      step();
    end
    chk("to_turn_ena", arb.ena, 4'b0000);
    chk("to_turn_busy", arb.busy, 1'b0);
    step();
    chk("to_regrant_ena", arb.ena, 4'b0001);
    chk("to_regrant_gnt_id", arb.gnt_id, 2'd0);
`else
    for (int c = 0; c < 10; c++) begin
      chk("hold_ena", arb.ena, 4'b0001);
      step();
    end
`endif

    // Reset during GRANT releases the bus at once; requester 0 wins afterwards.
    do_reset();
    rst_n   = 1'b1;
    arb.req = 4'b0010;
    step();
    chk("rg_own1_ena", arb.ena, 4'b0010);
    rst_n   = 1'b0;
    arb.req = 4'b0011;
    step();
    chk("rg_rst_ena", arb.ena, 4'b0000);
    chk("rg_rst_gnt_id", arb.gnt_id, 2'd0);
    chk("rg_rst_busy", arb.busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rg_after_ena", arb.ena, 4'b0001);
    chk("rg_after_gnt_id", arb.gnt_id, 2'd0);

    // Non-owner request changes do not disturb the owner.
    arb.req = 4'b1111;
    step();
    chk("nonown_ena_a", arb.ena, 4'b0001);
    arb.req = 4'b0101;
    step();
    chk("nonown_ena_b", arb.ena, 4'b0001);

    // Owner 0 drops, then requesters 0 and 3 ask during TURN: 3 wins, 0 is last.
    arb.req = 4'b0000;
    step();
    chk("prio_turn_ena", arb.ena, 4'b0000);
    arb.req = 4'b1001;
    step();
    chk("prio_ena", arb.ena, 4'b1000);
    chk("prio_gnt_id", arb.gnt_id, 2'd3);
    chk("prio_bus", bus, 8'h44);

    // Random requests: never multi-hot, and owners change only through an idle cycle.
    prev_ena = arb.ena;
    for (int n = 0; n < 10000; n++) begin
      arb.req = 4'($urandom);
      step();
      chk("rand_onehot", $onehot0(arb.ena), 1'b1);
      chk("rand_busy", arb.busy, arb.ena != 4'b0000);
      if (prev_ena != 4'b0000 && arb.ena != 4'b0000) chk("rand_sep", arb.ena, prev_ena);
      prev_ena = arb.ena;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
